reg_read_stage: RTL and testbench

REG_READ_STAGE -- requirements
Module: reg_read_stage

---
 rtl/reg_read_stage.sv | 211 +++++++++++++++++++++
 tb/tb_reg_read_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: integer and FP register files with same-cycle
// write bypass, a registered output stage with stall/flush, and held-operand refresh.

package reg_read_pkg;
    typedef logic [31:0] vaddr_t;
    typedef logic [31:0] insn_t;
    typedef logic [31:0] word_t;
    typedef logic [63:0] fword_t;
    typedef logic [11:0] csr_addr_t;
    typedef logic [5:0]  Op;

    typedef struct packed {
        logic        valid;
        logic [4:0]  cause;
        logic [31:0] value;
    } TrapInfo;
endpackage

module reg_read_stage
    import reg_read_pkg::*;
(
    input  logic      clk,
    input  logic      rstN,

    input  logic      prevValid,
    input  vaddr_t    prevPc,
    input  insn_t     prevInsn,
    input  logic      prevIsCompressedInsn,
    input  Op         prevOp,
    input  csr_addr_t prevCsrAddr,
    input  TrapInfo   prevTrapInfo,

    input  logic      intWriteEnable,
    input  logic [4:0] intWriteAddr,
    input  word_t     intWriteValue,

    input  logic      fpWriteEnable,
    input  logic [4:0] fpWriteAddr,
    input  fword_t    fpWriteValue,

    input  logic      stall,
    input  logic      flush,

    output logic      valid,
    output vaddr_t    pc,
    output insn_t     insn,
    output logic      isCompressedInsn,
    output Op         op,
    output csr_addr_t csrAddr,
    output word_t     srcIntRegValue1,
    output word_t     srcIntRegValue2,
    output fword_t    srcFpRegValue1,
    output fword_t    srcFpRegValue2,
    output fword_t    srcFpRegValue3,
    output TrapInfo   trapInfo
);

    word_t  int_rf_q [32];
    fword_t fp_rf_q  [32];

    logic      valid_q, valid_d;
    vaddr_t    pc_q, pc_d;
    insn_t     insn_q, insn_d;
    logic      is_c_q, is_c_d;
    Op         op_q, op_d;
    csr_addr_t csr_q, csr_d;
    TrapInfo   trap_q, trap_d;
    word_t     int1_q, int1_d, int2_q, int2_d;
    fword_t    fp1_q, fp1_d, fp2_q, fp2_d, fp3_q, fp3_d;

    logic [4:0] rs1, rs2, rs3;
    logic [4:0] held_rs1, held_rs2, held_rs3;
    word_t      rd_int1, rd_int2;
    fword_t     rd_fp1, rd_fp2, rd_fp3;

    // A write to x0 never counts as a hit, so x0 can never be bypassed.
    function automatic logic int_hit(input logic we, input logic [4:0] wa,
                                     input logic [4:0] idx);
        return we && (wa != 5'd0) && (wa == idx);
    endfunction

    function automatic logic fp_hit(input logic we, input logic [4:0] wa,
                                    input logic [4:0] idx);
        return we && (wa == idx);
    endfunction

    assign rs1      = prevInsn[19:15];
    assign rs2      = prevInsn[24:20];
    assign rs3      = prevInsn[31:27];
    assign held_rs1 = insn_q[19:15];
    assign held_rs2 = insn_q[24:20];
    assign held_rs3 = insn_q[31:27];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 32; i++) begin
                int_rf_q[i] <= '0;
            end
        end else if (intWriteEnable && (intWriteAddr != 5'd0)) begin
            int_rf_q[intWriteAddr] <= intWriteValue;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 32; i++) begin
                fp_rf_q[i] <= '0;
            end
        end else if (fpWriteEnable) begin
            fp_rf_q[fpWriteAddr] <= fpWriteValue;
        end
    end

    always_comb begin
        rd_int1 = '0;
        rd_int2 = '0;
        if (rs1 != 5'd0) begin
            rd_int1 = int_hit(intWriteEnable, intWriteAddr, rs1) ? intWriteValue
                                                                 : int_rf_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rd_int2 = int_hit(intWriteEnable, intWriteAddr, rs2) ? intWriteValue
                                                                 : int_rf_q[rs2];
        end
        rd_fp1 = fp_hit(fpWriteEnable, fpWriteAddr, rs1) ? fpWriteValue : fp_rf_q[rs1];
        rd_fp2 = fp_hit(fpWriteEnable, fpWriteAddr, rs2) ? fpWriteValue : fp_rf_q[rs2];
        rd_fp3 = fp_hit(fpWriteEnable, fpWriteAddr, rs3) ? fpWriteValue : fp_rf_q[rs3];
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        is_c_d  = is_c_q;
        op_d    = op_q;
        csr_d   = csr_q;
        trap_d  = trap_q;
        int1_d  = int1_q;
        int2_d  = int2_q;
        fp1_d   = fp1_q;
        fp2_d   = fp2_q;
        fp3_d   = fp3_q;

        if (flush || !stall) begin
            // Flush behaves like a normal capture with the instruction killed.
            valid_d = prevValid && !flush;
            pc_d    = prevPc;
            insn_d  = prevInsn;
            is_c_d  = prevIsCompressedInsn;
            op_d    = prevOp;
            csr_d   = prevCsrAddr;
            trap_d  = prevTrapInfo;
            int1_d  = rd_int1;
            int2_d  = rd_int2;
            fp1_d   = rd_fp1;
            fp2_d   = rd_fp2;
            fp3_d   = rd_fp3;
        end else begin
            // Stalled: keep the held operands coherent with writeback.
            if (int_hit(intWriteEnable, intWriteAddr, held_rs1)) int1_d = intWriteValue;
            if (int_hit(intWriteEnable, intWriteAddr, held_rs2)) int2_d = intWriteValue;
            if (fp_hit(fpWriteEnable, fpWriteAddr, held_rs1))    fp1_d  = fpWriteValue;
            if (fp_hit(fpWriteEnable, fpWriteAddr, held_rs2))    fp2_d  = fpWriteValue;
            if (fp_hit(fpWriteEnable, fpWriteAddr, held_rs3))    fp3_d  = fpWriteValue;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            insn_q  <= '0;
            is_c_q  <= 1'b0;
            op_q    <= '0;
            csr_q   <= '0;
            trap_q  <= '0;
            int1_q  <= '0;
            int2_q  <= '0;
            fp1_q   <= '0;
            fp2_q   <= '0;
            fp3_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            is_c_q  <= is_c_d;
            op_q    <= op_d;
            csr_q   <= csr_d;
            trap_q  <= trap_d;
            int1_q  <= int1_d;
            int2_q  <= int2_d;
            fp1_q   <= fp1_d;
            fp2_q   <= fp2_d;
            fp3_q   <= fp3_d;
        end
    end

    assign valid            = valid_q;
    assign pc               = pc_q;
    assign insn             = insn_q;
    assign isCompressedInsn = is_c_q;
    assign op               = op_q;
    assign csrAddr          = csr_q;
    assign trapInfo         = trap_q;
    assign srcIntRegValue1  = int1_q;
    assign srcIntRegValue2  = int2_q;
    assign srcFpRegValue1   = fp1_q;
    assign srcFpRegValue2   = fp2_q;
    assign srcFpRegValue3   = fp3_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: expected stage outputs are queued when
// stimulus is driven and compared after the capturing edge.

module tb_reg_read_stage;
    import reg_read_pkg::*;

    logic      clk = 1'b0;
    logic      rstN;
    logic      prevValid;
    vaddr_t    prevPc;
    insn_t     prevInsn;
    logic      prevIsCompressedInsn;
    Op         prevOp;
    csr_addr_t prevCsrAddr;
    TrapInfo   prevTrapInfo;
    logic      intWriteEnable;
    logic [4:0] intWriteAddr;
    word_t     intWriteValue;
    logic      fpWriteEnable;
    logic [4:0] fpWriteAddr;
    fword_t    fpWriteValue;
    logic      stall, flush;

    logic      valid;
    vaddr_t    pc;
    insn_t     insn;
    logic      isCompressedInsn;
    Op         op;
    csr_addr_t csrAddr;
    word_t     srcIntRegValue1, srcIntRegValue2;
    fword_t    srcFpRegValue1, srcFpRegValue2, srcFpRegValue3;
    TrapInfo   trapInfo;

    reg_read_stage dut (
        .clk(clk), .rstN(rstN),
        .prevValid(prevValid), .prevPc(prevPc), .prevInsn(prevInsn),
        .prevIsCompressedInsn(prevIsCompressedInsn), .prevOp(prevOp),
        .prevCsrAddr(prevCsrAddr), .prevTrapInfo(prevTrapInfo),
        .intWriteEnable(intWriteEnable), .intWriteAddr(intWriteAddr),
        .intWriteValue(intWriteValue),
        .fpWriteEnable(fpWriteEnable), .fpWriteAddr(fpWriteAddr),
        .fpWriteValue(fpWriteValue),
        .stall(stall), .flush(flush),
        .valid(valid), .pc(pc), .insn(insn), .isCompressedInsn(isCompressedInsn),
        .op(op), .csrAddr(csrAddr),
        .srcIntRegValue1(srcIntRegValue1), .srcIntRegValue2(srcIntRegValue2),
        .srcFpRegValue1(srcFpRegValue1), .srcFpRegValue2(srcFpRegValue2),
        .srcFpRegValue3(srcFpRegValue3), .trapInfo(trapInfo)
    );

    always #5 clk = ~clk;

    // care bits: 0 valid, 1 pc, 2 insn, 3 int1, 4 int2, 5 fp1, 6 fp2, 7 fp3, 8 trap
    typedef struct packed {
        logic [8:0]  care;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [63:0] f1;
        logic [63:0] f2;
        logic [63:0] f3;
        logic [37:0] trap;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    exp_t  e;
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [8:0] CARE_ALL = 9'h1FF;

    function automatic insn_t mk(input logic [4:0] r3, input logic [4:0] r2,
                                 input logic [4:0] r1);
        return {r3, 2'b00, r2, r1, 3'b000, 5'd1, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag);
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic compare_head();
        exp_t  x;
        string t;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        x = sb.pop_front();
        t = tags.pop_front();
        if (x.care[0]) chk({t, ".valid"}, {63'b0, valid}, {63'b0, x.valid});
        if (x.care[1]) chk({t, ".pc"},    {32'b0, pc},    {32'b0, x.pc});
        if (x.care[2]) chk({t, ".insn"},  {32'b0, insn},  {32'b0, x.insn});
        if (x.care[3]) chk({t, ".int1"},  {32'b0, srcIntRegValue1}, {32'b0, x.s1});
        if (x.care[4]) chk({t, ".int2"},  {32'b0, srcIntRegValue2}, {32'b0, x.s2});
        if (x.care[5]) chk({t, ".fp1"},   srcFpRegValue1, x.f1);
        if (x.care[6]) chk({t, ".fp2"},   srcFpRegValue2, x.f2);
        if (x.care[7]) chk({t, ".fp3"},   srcFpRegValue3, x.f3);
        if (x.care[8]) chk({t, ".trap"},  {26'b0, trapInfo}, {26'b0, x.trap});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check();
        tick();
        compare_head();
    endtask

    task automatic clear_writes();
        intWriteEnable = 1'b0; intWriteAddr = '0; intWriteValue = '0;
        fpWriteEnable  = 1'b0; fpWriteAddr  = '0; fpWriteValue  = '0;
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, ".valid"}, {63'b0, valid}, 64'd0);
        chk({tag, ".pc"},    {32'b0, pc}, 64'd0);
        chk({tag, ".insn"},  {32'b0, insn}, 64'd0);
        chk({tag, ".isc"},   {63'b0, isCompressedInsn}, 64'd0);
        chk({tag, ".op"},    {58'b0, op}, 64'd0);
        chk({tag, ".csr"},   {52'b0, csrAddr}, 64'd0);
        chk({tag, ".int1"},  {32'b0, srcIntRegValue1}, 64'd0);
        chk({tag, ".int2"},  {32'b0, srcIntRegValue2}, 64'd0);
        chk({tag, ".fp1"},   srcFpRegValue1, 64'd0);
        chk({tag, ".fp2"},   srcFpRegValue2, 64'd0);
        chk({tag, ".fp3"},   srcFpRegValue3, 64'd0);
        chk({tag, ".trap"},  {26'b0, trapInfo}, 64'd0);
    endtask

    initial begin
        rstN = 1'b0;
        prevValid = 1'b1; prevPc = 32'h0000_0BAD; prevInsn = mk(5'd3, 5'd2, 5'd1);
        prevIsCompressedInsn = 1'b1; prevOp = 6'h2A; prevCsrAddr = 12'h300;
        prevTrapInfo = '{valid: 1'b1, cause: 5'd3, value: 32'h1};
        stall = 1'b1; flush = 1'b0;
        // Writes during reset must be ignored.
        intWriteEnable = 1'b1; intWriteAddr = 5'd20; intWriteValue = 32'h0000_0BAD;
        fpWriteEnable  = 1'b1; fpWriteAddr  = 5'd3;  fpWriteValue  = 64'hBAD;
        #12;
        reset_outputs_check("reset");

        rstN = 1'b1;
        stall = 1'b0; prevValid = 1'b0;
        prevIsCompressedInsn = 1'b0; prevOp = '0; prevCsrAddr = '0; prevTrapInfo = '0;
        clear_writes();
        intWriteEnable = 1'b1; intWriteAddr = 5'd5; intWriteValue = 32'h1234_5678;
        tick();

        // Basic read of x5 written the cycle before.
        clear_writes();
        prevValid = 1'b1; prevPc = 32'h100; prevInsn = mk(5'd0, 5'd0, 5'd5);
        prevIsCompressedInsn = 1'b1; prevOp = 6'h11; prevCsrAddr = 12'h342;
        e = '0; e.care = 9'h01F; e.valid = 1'b1; e.pc = 32'h100;
        e.insn = mk(5'd0, 5'd0, 5'd5); e.s1 = 32'h1234_5678; e.s2 = 32'h0;
        push("basic");
        tick_check();
        chk("basic.isc", {63'b0, isCompressedInsn}, 64'd1);
        chk("basic.op",  {58'b0, op}, 64'h11);
        chk("basic.csr", {52'b0, csrAddr}, 64'h342);

        // Same-cycle write bypass into rs2.
        prevPc = 32'h104; prevInsn = mk(5'd0, 5'd7, 5'd5);
        prevIsCompressedInsn = 1'b0;
        intWriteEnable = 1'b1; intWriteAddr = 5'd7; intWriteValue = 32'hDEAD_BEEF;
        e = '0; e.care = 9'h01F; e.valid = 1'b1; e.pc = 32'h104;
        e.insn = mk(5'd0, 5'd7, 5'd5); e.s1 = 32'h1234_5678; e.s2 = 32'hDEAD_BEEF;
        push("bypass");
        tick_check();

        // x0 write bypass ignored; x20 written during reset still reads 0.
        prevPc = 32'h108; prevInsn = mk(5'd0, 5'd20, 5'd0);
        intWriteEnable = 1'b1; intWriteAddr = 5'd0; intWriteValue = 32'hFFFF_FFFF;
        e = '0; e.care = 9'h01F; e.valid = 1'b1; e.pc = 32'h108;
        e.insn = mk(5'd0, 5'd20, 5'd0); e.s1 = 32'h0; e.s2 = 32'h0;
        push("x0_bypass");
        tick_check();

        // Write f3, then read it via rs3 with an f0 bypass and a trap attached.
        clear_writes();
        prevValid = 1'b0;
        fpWriteEnable = 1'b1; fpWriteAddr = 5'd3; fpWriteValue = 64'h4009_21FB_5444_2D18;
        tick();
        prevValid = 1'b1; prevPc = 32'h180; prevInsn = mk(5'd3, 5'd0, 5'd0);
        prevTrapInfo = '{valid: 1'b1, cause: 5'd2, value: 32'h0000_ABCD};
        fpWriteEnable = 1'b1; fpWriteAddr = 5'd0; fpWriteValue = 64'h1111_2222_3333_4444;
        e = '0; e.care = CARE_ALL; e.valid = 1'b1; e.pc = 32'h180;
        e.insn = mk(5'd3, 5'd0, 5'd0); e.s1 = 32'h0; e.s2 = 32'h0;
        e.f1 = 64'h1111_2222_3333_4444; e.f2 = 64'h1111_2222_3333_4444;
        e.f3 = 64'h4009_21FB_5444_2D18;
        e.trap = {1'b1, 5'd2, 32'h0000_ABCD};
        push("fp_trap");
        tick_check();

        // Stall refresh of a held operand.
        clear_writes();
        prevTrapInfo = '0;
        prevValid = 1'b0;
        intWriteEnable = 1'b1; intWriteAddr = 5'd9; intWriteValue = 32'h1;
        tick();
        clear_writes();
        prevValid = 1'b1; prevPc = 32'h200; prevInsn = mk(5'd0, 5'd0, 5'd9);
        e = '0; e.care = 9'h01F; e.valid = 1'b1; e.pc = 32'h200;
        e.insn = mk(5'd0, 5'd0, 5'd9); e.s1 = 32'h1; e.s2 = 32'h0;
        push("stall_capture");
        tick_check();

        stall = 1'b1;
        prevValid = 1'b0; prevPc = 32'h300; prevInsn = mk(5'd0, 5'd0, 5'd1);
        intWriteEnable = 1'b1; intWriteAddr = 5'd0; intWriteValue = 32'h55;
        push("stall_c1");
        tick_check();
        intWriteEnable = 1'b1; intWriteAddr = 5'd9; intWriteValue = 32'h2;
        e.s1 = 32'h2;
        push("stall_c2");
        tick_check();
        clear_writes();
        push("stall_c3");
        tick_check();

        // Flush beats stall; the same-cycle write still lands in the file.
        flush = 1'b1; prevValid = 1'b1;
        intWriteEnable = 1'b1; intWriteAddr = 5'd12; intWriteValue = 32'hCAFE_F00D;
        e = '0; e.care = 9'h001; e.valid = 1'b0;
        push("flush_prio");
        tick_check();
        clear_writes();
        flush = 1'b0; stall = 1'b0;
        prevPc = 32'h400; prevInsn = mk(5'd0, 5'd0, 5'd12);
        e = '0; e.care = 9'h01F; e.valid = 1'b1; e.pc = 32'h400;
        e.insn = mk(5'd0, 5'd0, 5'd12); e.s1 = 32'hCAFE_F00D; e.s2 = 32'h0;
        push("after_flush");
        tick_check();

        // Reset asserted mid-stall.
        stall = 1'b1; prevValid = 1'b0; prevPc = 32'h999;
        push("pre_reset_hold");
        tick_check();
        #2;
        rstN = 1'b0;
        #1;
        reset_outputs_check("reset_mid_stall");
        #2;
        rstN = 1'b1;
        stall = 1'b0;
        prevValid = 1'b1; prevPc = 32'h500; prevInsn = mk(5'd3, 5'd7, 5'd5);
        e = '0; e.care = CARE_ALL; e.valid = 1'b1; e.pc = 32'h500;
        e.insn = mk(5'd3, 5'd7, 5'd5);
        push("post_reset_regs");
        tick_check();
        prevInsn = mk(5'd0, 5'd12, 5'd9);
        e.insn = mk(5'd0, 5'd12, 5'd9);
        push("post_reset_regs2");
        tick_check();

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
